// File: rtl/cache_miss_handler.sv
// ============================================================================
// cache_miss_handler : one-outstanding-miss refill / write-back engine
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_miss_handler #(
  parameter int WIDTH = 32,
  parameter int B     = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_valid_i,
  output logic               miss_ready_o,
  input  logic [WIDTH-1:0]   miss_addr_i,
  input  logic               victim_dirty_i,
  input  logic [WIDTH-1:0]   victim_addr_i,
  input  logic [B*8-1:0]     victim_data_i,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic               mem_req_we_o,
  output logic [WIDTH-1:0]   mem_req_addr_o,
  output logic [B*8-1:0]     mem_req_data_o,
  input  logic               mem_resp_valid_i,
  input  logic [B*8-1:0]     mem_resp_data_i,
  output logic               fill_valid_o,
  output logic [WIDTH-1:0]   fill_addr_o,
  output logic [B*8-1:0]     fill_data_o,
  output logic [CNT_W-1:0]   miss_count_o,
  output logic [CNT_W-1:0]   wb_count_o
);

  localparam int              OFS       = $clog2(B);
  localparam int              DW        = B * 8;
  localparam logic [WIDTH-1:0] LINE_MASK = {WIDTH{1'b1}} << OFS;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    FILL    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  miss_line_q, miss_line_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              mem_req_we_q, mem_req_we_d;
  logic [WIDTH-1:0]  mem_req_addr_q, mem_req_addr_d;
  logic [DW-1:0]     mem_req_data_q, mem_req_data_d;
  logic              fill_valid_q, fill_valid_d;
  logic [WIDTH-1:0]  fill_addr_q, fill_addr_d;
  logic [DW-1:0]     fill_data_q, fill_data_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;
  logic [CNT_W-1:0]  wb_count_q, wb_count_d;

  always_comb begin
    state_d         = state_q;
    miss_line_d     = miss_line_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_data_d  = mem_req_data_q;
    fill_valid_d    = 1'b0;
    fill_addr_d     = fill_addr_q;
    fill_data_d     = fill_data_q;
    miss_count_d    = miss_count_q;
    wb_count_d      = wb_count_q;

    case (state_q)
      IDLE: begin
        if (miss_valid_i) begin
          miss_line_d     = miss_addr_i & LINE_MASK;
          mem_req_valid_d = 1'b1;
          if (miss_count_q != CNT_MAX) miss_count_d = miss_count_q + CNT_ONE;
          // The first request is loaded here so valid rises the cycle after acceptance.
          if (victim_dirty_i) begin
            mem_req_we_d   = 1'b1;
            mem_req_addr_d = victim_addr_i & LINE_MASK;
            mem_req_data_d = victim_data_i;
            state_d        = WB_REQ;
          end else begin
            mem_req_we_d   = 1'b0;
            mem_req_addr_d = miss_addr_i & LINE_MASK;
            mem_req_data_d = '0;
            state_d        = RD_REQ;
          end
        end
      end
      WB_REQ: begin
        if (mem_req_ready_i) begin
          if (wb_count_q != CNT_MAX) wb_count_d = wb_count_q + CNT_ONE;
          mem_req_we_d   = 1'b0;
          mem_req_addr_d = miss_line_q;
          mem_req_data_d = '0;
          state_d        = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_req_ready_i) begin
          mem_req_valid_d = 1'b0;
          state_d         = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_resp_valid_i) begin
          fill_valid_d = 1'b1;
          fill_addr_d  = miss_line_q;
          fill_data_d  = mem_resp_data_i;
          state_d      = FILL;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      miss_line_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
      fill_valid_q    <= 1'b0;
      fill_addr_q     <= '0;
      fill_data_q     <= '0;
      miss_count_q    <= '0;
      wb_count_q      <= '0;
    end else begin
      state_q         <= state_d;
      miss_line_q     <= miss_line_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_data_q  <= mem_req_data_d;
      fill_valid_q    <= fill_valid_d;
      fill_addr_q     <= fill_addr_d;
      fill_data_q     <= fill_data_d;
      miss_count_q    <= miss_count_d;
      wb_count_q      <= wb_count_d;
    end
  end

  assign miss_ready_o    = (state_q == IDLE);
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_we_o    = mem_req_we_q;
  assign mem_req_addr_o  = mem_req_addr_q;
  assign mem_req_data_o  = mem_req_data_q;
  assign fill_valid_o    = fill_valid_q;
  assign fill_addr_o     = fill_addr_q;
  assign fill_data_o     = fill_data_q;
  assign miss_count_o    = miss_count_q;
  assign wb_count_o      = wb_count_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_miss_handler.sv
// ============================================================================
// tb_cache_miss_handler : directed bench for cache_miss_handler (CNT_W = 2)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_miss_handler;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [31:0] miss_addr_i;
  logic        victim_dirty_i;
  logic [31:0] victim_addr_i;
  logic [31:0] victim_data_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_req_we_o;
  logic [31:0] mem_req_addr_o;
  logic [31:0] mem_req_data_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_data_i;
  logic        fill_valid_o;
  logic [31:0] fill_addr_o;
  logic [31:0] fill_data_o;
  logic [1:0]  miss_count_o;
  logic [1:0]  wb_count_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_miss_handler #(.WIDTH(32), .B(4), .CNT_W(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_valid_i     (miss_valid_i),
    .miss_ready_o     (miss_ready_o),
    .miss_addr_i      (miss_addr_i),
    .victim_dirty_i   (victim_dirty_i),
    .victim_addr_i    (victim_addr_i),
    .victim_data_i    (victim_data_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_we_o     (mem_req_we_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_data_o   (mem_req_data_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
    .fill_valid_o     (fill_valid_o),
    .fill_addr_o      (fill_addr_o),
    .fill_data_o      (fill_data_o),
    .miss_count_o     (miss_count_o),
    .wb_count_o       (wb_count_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    chk({tag, ".valid"}, 64'(mem_req_valid_o), 64'(v));
    chk({tag, ".we"},    64'(mem_req_we_o),    64'(we));
    chk({tag, ".addr"},  64'(mem_req_addr_o),  64'(a));
    chk({tag, ".data"},  64'(mem_req_data_o),  64'(d));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".miss_ready"}, 64'(miss_ready_o), 64'(1));
    chk_req({tag, ".req"}, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({tag, ".fill_valid"}, 64'(fill_valid_o), 64'(0));
    chk({tag, ".fill_addr"},  64'(fill_addr_o),  64'(0));
    chk({tag, ".fill_data"},  64'(fill_data_o),  64'(0));
    chk({tag, ".miss_cnt"},   64'(miss_count_o), 64'(0));
    chk({tag, ".wb_cnt"},     64'(wb_count_o),   64'(0));
  endtask

  initial begin
    rst = 1'b1; miss_valid_i = 1'b0; miss_addr_i = '0; victim_dirty_i = 1'b0;
    victim_addr_i = '0; victim_data_i = '0; mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    tick(); tick();
    rst = 1'b0;
    chk_reset_state("reset");

    // Clean miss; victim inputs carry data but are not dirty.
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_1006; victim_dirty_i = 1'b0;
    victim_addr_i = 32'h0000_7770; victim_data_i = 32'hBAD0BAD0; mem_req_ready_i = 1'b1;
    tick();                                   // N+1
    miss_valid_i = 1'b0;
    chk_req("clean.rdreq", 1'b1, 1'b0, 32'h0000_1004, 32'h0);
    chk("clean.busy", 64'(miss_ready_o), 64'(0));
    chk("clean.mcnt", 64'(miss_count_o), 64'(1));
    tick();                                   // N+2
    chk("clean.req_drop", 64'(mem_req_valid_o), 64'(0));
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hDEADBEEF;
    tick();                                   // N+3
    mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
    chk("clean.fill_v", 64'(fill_valid_o), 64'(1));
    chk("clean.fill_a", 64'(fill_addr_o),  64'(32'h0000_1004));
    chk("clean.fill_d", 64'(fill_data_o),  64'(32'hDEADBEEF));
    chk("clean.rdy_n3", 64'(miss_ready_o), 64'(0));
    tick();                                   // N+4
    chk("clean.fill_1cyc", 64'(fill_valid_o), 64'(0));
    chk("clean.rdy_n4",    64'(miss_ready_o), 64'(1));
    chk("clean.wbcnt",     64'(wb_count_o),   64'(0));

    // Dirty miss, memory always ready.
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_3000; victim_dirty_i = 1'b1;
    victim_addr_i = 32'h0000_2000; victim_data_i = 32'hCAFEF00D;
    tick();                                   // N+1
    miss_valid_i = 1'b0; victim_dirty_i = 1'b0;
    chk_req("dirty.wbreq", 1'b1, 1'b1, 32'h0000_2000, 32'hCAFEF00D);
    tick();                                   // N+2
    chk_req("dirty.rdreq", 1'b1, 1'b0, 32'h0000_3000, 32'h0);
    chk("dirty.wbcnt", 64'(wb_count_o), 64'(1));
    tick();                                   // N+3
    chk("dirty.req_drop", 64'(mem_req_valid_o), 64'(0));
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h1234_5678;
    tick();                                   // N+4
    mem_resp_valid_i = 1'b0;
    chk("dirty.fill_v", 64'(fill_valid_o), 64'(1));
    chk("dirty.fill_a", 64'(fill_addr_o),  64'(32'h0000_3000));
    chk("dirty.fill_d", 64'(fill_data_o),  64'(32'h1234_5678));
    tick();                                   // N+5
    chk("dirty.rdy", 64'(miss_ready_o), 64'(1));
    chk("dirty.mcnt", 64'(miss_count_o), 64'(2));

    // Backpressure on the write-back, plus a competing miss and spurious responses.
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_5003; victim_dirty_i = 1'b1;
    victim_addr_i = 32'h0000_4002; victim_data_i = 32'h1122_3344; mem_req_ready_i = 1'b0;
    tick();
    miss_addr_i = 32'h0000_9000; victim_addr_i = 32'h0000_A000; victim_data_i = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      chk_req($sformatf("bp.hold%0d", i), 1'b1, 1'b1, 32'h0000_4000, 32'h1122_3344);
      chk($sformatf("bp.busy%0d", i), 64'(miss_ready_o), 64'(0));
      if (i == 4) mem_req_ready_i = 1'b1;
      tick();
    end
    miss_valid_i = 1'b0; victim_dirty_i = 1'b0;
    chk_req("bp.rdreq", 1'b1, 1'b0, 32'h0000_5000, 32'h0);
    chk("bp.wbcnt_once", 64'(wb_count_o), 64'(2));
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h0BAD_0BAD;
    tick();
    chk_req("bp.rdreq_hold", 1'b1, 1'b0, 32'h0000_5000, 32'h0);
    chk("bp.spur_rdreq_fill", 64'(fill_valid_o), 64'(0));
    mem_resp_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    tick();
    chk("bp.req_drop", 64'(mem_req_valid_o), 64'(0));
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h55AA_55AA;
    tick();
    mem_resp_valid_i = 1'b0;
    chk("bp.fill_a", 64'(fill_addr_o), 64'(32'h0000_5000));
    chk("bp.fill_d", 64'(fill_data_o), 64'(32'h55AA_55AA));
    tick();
    chk("bp.rdy", 64'(miss_ready_o), 64'(1));
    chk("bp.mcnt", 64'(miss_count_o), 64'(3));
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hEEEE_EEEE;
    tick();
    mem_resp_valid_i = 1'b0;
    chk("idle.spur_fill", 64'(fill_valid_o), 64'(0));
    chk("idle.spur_rdy",  64'(miss_ready_o), 64'(1));
    chk("idle.spur_req",  64'(mem_req_valid_o), 64'(0));

    // Reset while waiting for a read response.
    miss_valid_i = 1'b1; miss_addr_i = 32'h0000_6001;
    tick();
    miss_valid_i = 1'b0;
    tick();                                   // now in RD_WAIT
    rst = 1'b1; mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h9999_9999;
    tick();
    rst = 1'b0;
    chk_reset_state("rstwait");
    tick();
    mem_resp_valid_i = 1'b0;
    chk("rstwait.nofill", 64'(fill_valid_o), 64'(0));
    chk("rstwait.rdy",    64'(miss_ready_o), 64'(1));

    // Counter saturation at 2'b11.
    for (int i = 0; i < 5; i++) begin
      miss_valid_i = 1'b1; miss_addr_i = 32'h0000_8000 + 32'(i * 4);
      tick();
      miss_valid_i = 1'b0;
      chk($sformatf("sat.mcnt%0d", i), 64'(miss_count_o), 64'((i < 3) ? i + 1 : 3));
      tick();
      mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'h0000_0100 + 32'(i);
      tick();
      mem_resp_valid_i = 1'b0;
      chk($sformatf("sat.fill%0d", i), 64'(fill_data_o), 64'(32'h0000_0100 + 32'(i)));
      tick();
    end
    chk("sat.wbcnt", 64'(wb_count_o), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_miss_handler.md
# cache_miss_handler

Refill/write-back engine sitting directly downstream of the fully associative cache, between the cache and backing memory. On a cache miss it accepts one miss request with an optional dirty victim. It writes the victim back if needed, then fetches the missing line. It returns that line to the cache as a single-cycle fill. One miss is outstanding at a time; memory uses a valid/ready request channel and a valid-only response channel.

## Interface
- WIDTH, 32, address width in bits
- B, 4, line size in bytes; line data is B*8 bits; OFS = $clog2(B)
- CNT_W, 16, width of statistics counters
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- miss_valid_i  input  1  cache presents a miss
- miss_ready_o  output  1  handler can accept a miss
- miss_addr_i  input  WIDTH  missing address (any byte offset)
- victim_dirty_i  input  1  evicted line must be written back
- victim_addr_i  input  WIDTH  victim line address
- victim_data_i  input  B*8  victim line data
- mem_req_valid_o  output  1  memory request valid
- mem_req_ready_i  input  1  memory accepts request
- mem_req_we_o  output  1  1 = write-back, 0 = line read
- mem_req_addr_o  output  WIDTH  line-aligned request address
- mem_req_data_o  output  B*8  write data (victim line)
- mem_resp_valid_i  input  1  read data valid
- mem_resp_data_i  input  B*8  read line data
- fill_valid_o  output  1  one-cycle fill strobe to cache
- fill_addr_o  output  WIDTH  line-aligned fill address
- fill_data_o  output  B*8  fill line data
- miss_count_o  output  CNT_W  accepted misses, saturating
- wb_count_o  output  CNT_W  completed write-backs, saturating

## Operation
- FSM states: IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL.
- miss_ready_o = (state == IDLE). A miss is accepted when miss_valid_i && miss_ready_o.
- On acceptance, register the line-aligned miss address (low OFS bits forced to 0), the line-aligned victim address, victim data and the dirty flag. Increment miss_count_o.
- From IDLE, the next state is WB_REQ if victim_dirty_i is set, else RD_REQ.
- WB_REQ drives mem_req_valid_o=1, we=1, addr=victim line, data=victim data. On mem_req_ready_i the state goes to RD_REQ and wb_count_o increments. Writes are posted and have no response.
- RD_REQ drives mem_req_valid_o=1, we=0, addr=miss line. mem_req_data_o is don't-care, driven as 0. On mem_req_ready_i the state goes to RD_WAIT.
- RD_WAIT waits for mem_resp_valid_i, then captures mem_resp_data_i and goes to FILL.
- FILL asserts fill_valid_o for exactly one cycle with the registered address and data, then returns to IDLE. The cache must absorb the fill; there is no backpressure.
- mem_req_* outputs are held stable while valid is high and ready is low.
- mem_resp_valid_i is ignored in every state except RD_WAIT.
- Counters saturate at all-ones and never wrap.
- miss_valid_i is ignored whenever the state is not IDLE.

## Timing
- Reset values:
  - state IDLE
  - miss_ready_o=1
  - mem_req_valid_o=0, mem_req_we_o=0, mem_req_addr_o=0, mem_req_data_o=0
  - fill_valid_o=0, fill_addr_o=0, fill_data_o=0
  - both counters 0
- Miss accepted in cycle N:
  - mem_req_valid_o rises at N+1.
  - The first request handshake is no earlier than N+1.
- Clean miss, memory always ready, response one cycle after the request handshake:
  - read handshake at N+1, response at N+2, fill_valid_o at N+3, miss_ready_o high again at N+4.
- Dirty miss under the same conditions:
  - write handshake at N+1, read handshake at N+2, response at N+3, fill at N+4, ready at N+5.
- The fill appears exactly one cycle after the response cycle.
- Reset in any state: the next cycle is IDLE with all outputs at reset values. An in-flight memory response is discarded and no fill is issued.
- Accepted miss with victim_dirty_i=0 while victim inputs carry data: no write request is ever issued.

## Test plan
- Reset, then clean miss at addr 0x0000_1006 with memory always ready and response data 0xDEADBEEF one cycle after the request.
  - Expect read req addr 0x0000_1004, we=0.
  - Expect fill_valid_o at N+3 with addr 0x0000_1004, data 0xDEADBEEF.
  - Expect miss_count_o=1, wb_count_o=0.
- Dirty miss: victim 0x0000_2000 with data 0xCAFEF00D, miss addr 0x0000_3000.
  - Expect a write req (we=1, addr 0x0000_2000, data 0xCAFEF00D), then a read req to 0x0000_3000.
  - Expect the fill at N+4 and wb_count_o=1.
- Backpressure: hold mem_req_ready_i=0 for 5 cycles.
  - Expect mem_req_valid/addr/data/we stable for all 5 cycles and one handshake only.
  - miss_ready_o stays 0; a second miss_valid_i is not accepted.
- Spurious mem_resp_valid_i=1 in IDLE and RD_REQ: no fill and no state change. Only the response in RD_WAIT produces the fill.
- Assert rst while in RD_WAIT, then return a response.
  - Expect no fill_valid_o and all outputs at reset values.
  - Expect miss_ready_o=1 the cycle after reset.
- Counter saturation with CNT_W=2: issue 5 misses and expect miss_count_o to stay at 3 after the third miss.
